// File: rtl/cnn_pkg.sv
// Shared encodings and dimension helpers for the CNN convolution engine.
package cnn_pkg;

    // Operation selected by the start command
    typedef enum logic [1:0] {
        MODE_CONV      = 2'b00,
        MODE_CONV_RELU = 2'b01,
        MODE_POOL      = 2'b10,
        MODE_RSVD      = 2'b11
    } cnn_mode_e;

    // Engine sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_F,
        ST_RUN,
        ST_WRITE,
        ST_DONE
    } cnn_state_e;

    // Accumulator width able to hold K*K full-precision products
    function automatic int acc_width(input int n, input int k);
        return 2 * n + $clog2(k * k);
    endfunction

    // Output dimension for a stride-1, valid-padding convolution
    function automatic int conv_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    // Output dimension for 2x2 stride-2 pooling (odd trailing line dropped)
    function automatic int pool_dim(input int img);
        return img / 2;
    endfunction

endpackage

// File: rtl/cnn_post.sv
// Result post-processing: arithmetic shift, signed saturation, optional ReLU.
module cnn_post #(
    parameter int N     = 8,
    parameter int ACC_W = 20,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic                    relu,
    output logic        [N-1:0]     res
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (N - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (N - 1)));

    logic signed [ACC_W-1:0] shifted;

    // Scale, clamp to the N-bit signed range, then zero negatives under ReLU
    always_comb begin
        shifted = acc >>> SHIFT;
        if (shifted > SAT_MAX) begin
            res = SAT_MAX[N-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[N-1:0];
        end else begin
            res = shifted[N-1:0];
        end
        if (relu && shifted[ACC_W-1]) begin
            res = '0;
        end
    end

endmodule

// File: rtl/cnn_conv_engine.sv
// Sequenced conv / conv+ReLU / 2x2 max-pool engine walking a whole image plane.
module cnn_conv_engine
    import cnn_pkg::*;
#(
    parameter int N     = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3,
    parameter int M_AW  = 10,
    parameter int F_AW  = 4,
    parameter int SHIFT = 0,
    parameter int ACC_W = acc_width(N, K)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [M_AW-1:0] img_base,
    input  logic [F_AW-1:0] fil_base,
    input  logic [M_AW-1:0] out_base,
    output logic            img_rd_en,
    output logic [M_AW-1:0] img_addr,
    input  logic [N-1:0]    img_data,
    output logic            fil_rd_en,
    output logic [F_AW-1:0] fil_addr,
    input  logic [N-1:0]    fil_data,
    output logic            out_wr_en,
    output logic [M_AW-1:0] out_addr,
    output logic [N-1:0]    out_data,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int KK    = K * K;
    localparam int T_MAX = (KK > 4) ? KK : 4;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int KW    = $clog2(K + 1);
    localparam int RW    = $clog2(IMG_H + 1);
    localparam int CW    = $clog2(IMG_W + 1);
    localparam int OH    = conv_dim(IMG_H, K);
    localparam int OW    = conv_dim(IMG_W, K);
    localparam int PH    = pool_dim(IMG_H);
    localparam int PW    = pool_dim(IMG_W);

    localparam logic [TW-1:0] T_CONV  = TW'(KK);
    localparam logic [TW-1:0] T_POOL  = TW'(4);
    localparam logic [KW-1:0] KL_CONV = KW'(K - 1);
    localparam logic [KW-1:0] KL_POOL = KW'(1);
    localparam logic [RW-1:0] RL_CONV = RW'(OH - 1);
    localparam logic [RW-1:0] RL_POOL = RW'(PH - 1);
    localparam logic [CW-1:0] CL_CONV = CW'(OW - 1);
    localparam logic [CW-1:0] CL_POOL = CW'(PW - 1);

    cnn_state_e              state;
    cnn_mode_e               mode_q;
    logic [M_AW-1:0]         img_base_q, out_base_q;
    logic [F_AW-1:0]         fil_base_q;
    logic [RW-1:0]           row, row_nxt, row_last;
    logic [CW-1:0]           col, col_nxt, col_last;
    logic [KW-1:0]           ti, tj, ti_nxt, tj_nxt, tap_last;
    logic [TW-1:0]           tap, tap_inc, tap_end;
    logic signed [ACC_W-1:0] acc, acc_nxt, samp;
    logic signed [2*N-1:0]   prod;
    logic signed [N-1:0]     coef [KK];
    logic                    is_pool, last_pix;
    logic [31:0]             plane_w;
    logic [N-1:0]            post_res;

    // Image address of tap (i,j) for output pixel (r,c), wrapping modulo 2^M_AW
    function automatic logic [M_AW-1:0] tap_addr(input logic [M_AW-1:0] base, input logic pool,
                                                 input logic [31:0] r, input logic [31:0] c,
                                                 input logic [31:0] i, input logic [31:0] j);
        logic [31:0] y, x;
        y = pool ? (2 * r + i) : (r + i);
        x = pool ? (2 * c + j) : (c + j);
        return base + M_AW'(y * IMG_W + x);
    endfunction

    // Mode-dependent limits and next tap / next pixel indices
    always_comb begin
        is_pool  = (mode_q == MODE_POOL);
        tap_end  = is_pool ? T_POOL : T_CONV;
        tap_inc  = tap + 1'b1;
        tap_last = is_pool ? KL_POOL : KL_CONV;
        row_last = is_pool ? RL_POOL : RL_CONV;
        col_last = is_pool ? CL_POOL : CL_CONV;
        plane_w  = is_pool ? 32'(PW) : 32'(OW);
        last_pix = (row == row_last) && (col == col_last);
        if (tj == tap_last) begin
            tj_nxt = '0;
            ti_nxt = ti + 1'b1;
        end else begin
            tj_nxt = tj + 1'b1;
            ti_nxt = ti;
        end
        if (col == col_last) begin
            col_nxt = '0;
            row_nxt = row + 1'b1;
        end else begin
            col_nxt = col + 1'b1;
            row_nxt = row;
        end
    end

    // Accumulate or running-max on the data returned for the previous tap
    always_comb begin
        prod    = $signed(img_data) * coef[0];
        samp    = ACC_W'($signed(img_data));
        acc_nxt = acc;
        if (state == ST_RUN && tap != '0) begin
            if (is_pool) begin
                if (tap == TW'(1) || samp > acc) begin
                    acc_nxt = samp;
                end
            end else if (tap == TW'(1)) begin
                acc_nxt = ACC_W'(prod);
            end else begin
                acc_nxt = acc + ACC_W'(prod);
            end
        end
    end

    cnn_post #(
        .N     (N),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_post (
        .acc  (acc_nxt),
        .relu (mode_q == MODE_CONV_RELU),
        .res  (post_res)
    );

    // Sequencer with registered memory strobes, results and status
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_CONV;
            img_base_q <= '0;
            fil_base_q <= '0;
            out_base_q <= '0;
            row        <= '0;
            col        <= '0;
            ti         <= '0;
            tj         <= '0;
            tap        <= '0;
            acc        <= '0;
            for (int unsigned t = 0; t < KK; t++) coef[t] <= '0;
            img_rd_en  <= 1'b0;
            img_addr   <= '0;
            fil_rd_en  <= 1'b0;
            fil_addr   <= '0;
            out_wr_en  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            img_rd_en <= 1'b0;
            fil_rd_en <= 1'b0;
            out_wr_en <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            acc       <= acc_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q     <= cnn_mode_e'(mode);
                        img_base_q <= img_base;
                        fil_base_q <= fil_base;
                        out_base_q <= out_base;
                        row        <= '0;
                        col        <= '0;
                        ti         <= '0;
                        tj         <= '0;
                        tap        <= '0;
                        case (cnn_mode_e'(mode))
                            MODE_CONV, MODE_CONV_RELU: begin
                                state     <= ST_LOAD_F;
                                busy      <= 1'b1;
                                fil_rd_en <= 1'b1;
                                fil_addr  <= fil_base;
                            end
                            MODE_POOL: begin
                                state     <= ST_RUN;
                                busy      <= 1'b1;
                                img_rd_en <= 1'b1;
                                img_addr  <= img_base;
                            end
                            default: begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                                err   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_LOAD_F: begin
                    // Coefficients shift in from the top so coef[0] ends up holding tap 0
                    if (tap != '0) begin
                        for (int unsigned t = 0; t + 1 < KK; t++) coef[t] <= coef[t + 1];
                        coef[KK-1] <= $signed(fil_data);
                    end
                    if (tap == T_CONV) begin
                        state     <= ST_RUN;
                        tap       <= '0;
                        img_rd_en <= 1'b1;
                        img_addr  <= img_base_q;
                    end else begin
                        tap <= tap_inc;
                        if (tap_inc < T_CONV) begin
                            fil_rd_en <= 1'b1;
                            fil_addr  <= fil_base_q + F_AW'(tap_inc);
                        end
                    end
                end
                ST_RUN: begin
                    // Rotating the bank K*K times per pixel leaves it back in tap order
                    if (!is_pool && tap != '0) begin
                        for (int unsigned t = 0; t + 1 < KK; t++) coef[t] <= coef[t + 1];
                        coef[KK-1] <= coef[0];
                    end
                    if (tap == tap_end) begin
                        state     <= ST_WRITE;
                        tap       <= '0;
                        ti        <= '0;
                        tj        <= '0;
                        out_wr_en <= 1'b1;
                        out_addr  <= out_base_q + M_AW'(32'(row) * plane_w + 32'(col));
                        out_data  <= is_pool ? acc_nxt[N-1:0] : post_res;
                    end else begin
                        tap <= tap_inc;
                        if (tap_inc < tap_end) begin
                            ti        <= ti_nxt;
                            tj        <= tj_nxt;
                            img_rd_en <= 1'b1;
                            img_addr  <= tap_addr(img_base_q, is_pool, 32'(row), 32'(col),
                                                  32'(ti_nxt), 32'(tj_nxt));
                        end
                    end
                end
                ST_WRITE: begin
                    if (last_pix) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state     <= ST_RUN;
                        row       <= row_nxt;
                        col       <= col_nxt;
                        img_rd_en <= 1'b1;
                        img_addr  <= tap_addr(img_base_q, is_pool, 32'(row_nxt), 32'(col_nxt),
                                              32'd0, 32'd0);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Scoreboard bench for cnn_conv_engine on a 4x4 image with a 3x3 filter.
module tb_cnn_conv_engine;

    localparam int N     = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int K     = 3;
    localparam int M_AW  = 6;
    localparam int F_AW  = 4;
    localparam int SHIFT = 0;
    localparam int OW    = IMG_W - K + 1;
    localparam int OH    = IMG_H - K + 1;
    localparam int PW    = IMG_W / 2;
    localparam int PH    = IMG_H / 2;

    logic            clock = 1'b0;
    logic            reset, start;
    logic [1:0]      mode;
    logic [M_AW-1:0] img_base, out_base, img_addr, out_addr;
    logic [F_AW-1:0] fil_base, fil_addr;
    logic            img_rd_en, fil_rd_en, out_wr_en, busy, done, err;
    logic [N-1:0]    img_data, fil_data, out_data;

    always #5 clock = ~clock;

    cnn_conv_engine #(
        .N     (N),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .M_AW  (M_AW),
        .F_AW  (F_AW),
        .SHIFT (SHIFT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .img_base  (img_base),
        .fil_base  (fil_base),
        .out_base  (out_base),
        .img_rd_en (img_rd_en),
        .img_addr  (img_addr),
        .img_data  (img_data),
        .fil_rd_en (fil_rd_en),
        .fil_addr  (fil_addr),
        .fil_data  (fil_data),
        .out_wr_en (out_wr_en),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    logic signed [7:0] img_mem [64];
    logic signed [7:0] fil_mem [16];

    // Synchronous-read memories
    always @(posedge clock) begin
        if (img_rd_en) img_data <= img_mem[img_addr];
        if (fil_rd_en) fil_data <= fil_mem[fil_addr];
    end

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0, n_fail = 0;
    int  n_img_rd, n_fil_rd, n_wr, n_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor and strobe counters
    always @(negedge clock) begin
        if (!reset) begin
            if (img_rd_en) n_img_rd++;
            if (fil_rd_en) n_fil_rd++;
            if (done) n_done++;
            if (out_wr_en) begin
                wr_t e;
                n_wr++;
                check_eq("wr_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("wr_addr", 32'(out_addr), 32'(e.addr));
                    check_eq("wr_data", 32'(out_data), 32'(e.data));
                end
            end
        end
    end

    function automatic logic [7:0] sat_post(input longint a, input bit relu);
        longint v;
        v = a >>> SHIFT;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        if (relu && v < 0) v = 0;
        return 8'(v);
    endfunction

    task automatic push_expected(input logic [1:0] md, input int ib, input int fb, input int ob);
        wr_t    e;
        longint a, v;
        int     rows, cols;
        if (md == 2'b11) return;
        rows = (md == 2'b10) ? PH : OH;
        cols = (md == 2'b10) ? PW : OW;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (md == 2'b10) begin
                    a = img_mem[(ib + 2 * r * IMG_W + 2 * c) & 63];
                    for (int i = 0; i < 2; i++)
                        for (int j = 0; j < 2; j++) begin
                            v = img_mem[(ib + (2 * r + i) * IMG_W + 2 * c + j) & 63];
                            if (v > a) a = v;
                        end
                    e.data = 8'(a);
                end else begin
                    a = 0;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            a += longint'(img_mem[(ib + (r + i) * IMG_W + c + j) & 63]) *
                                 longint'(fil_mem[(fb + i * K + j) & 15]);
                    e.data = sat_post(a, md == 2'b01);
                end
                e.addr = 6'((ob + r * cols + c) & 63);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_job(input logic [1:0] md, input int ib, input int fb, input int ob,
                           input int exp_cyc, input bit exp_err, input int poke_cyc,
                           input bit poke_done);
        int cyc;
        bit busy1;
        push_expected(md, ib, fb, ob);
        n_img_rd = 0;
        n_fil_rd = 0;
        n_done   = 0;
        n_wr     = 0;
        @(negedge clock);
        mode     = md;
        img_base = 6'(ib);
        fil_base = 4'(fb);
        out_base = 6'(ob);
        start    = 1'b1;
        cyc      = 0;
        busy1    = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clock);
            cyc++;
            start = (poke_cyc != 0 && cyc == poke_cyc);
            if (cyc == 1) busy1 = busy;
        end
        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("cycles", 32'(cyc), 32'(exp_cyc));
        check_eq("err", 32'(err), 32'(exp_err));
        check_eq("busy_at_done", 32'(busy), 32'd0);
        check_eq("busy_run", 32'(busy1), 32'(md != 2'b11));
        start = poke_done;
        @(negedge clock);
        start = 1'b0;
        check_eq("done_pulse", 32'(done), 32'd0);
        repeat (3) @(negedge clock);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("done_count", 32'(n_done), 32'd1);
        check_eq("writes", 32'(n_wr), (md == 2'b11) ? 32'd0 : 32'd4);
        check_eq("writes_left", 32'(exp_q.size()), 32'd0);
        check_eq("img_reads", 32'(n_img_rd),
                 (md == 2'b11) ? 32'd0 : (md == 2'b10) ? 32'(PH * PW * 4) : 32'(OH * OW * K * K));
        check_eq("fil_reads", 32'(n_fil_rd), (md[1] == 1'b0) ? 32'(K * K) : 32'd0);
        exp_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_img_rd"}, 32'(img_rd_en), 32'd0);
        check_eq({tag, "_img_addr"}, 32'(img_addr), 32'd0);
        check_eq({tag, "_fil_rd"}, 32'(fil_rd_en), 32'd0);
        check_eq({tag, "_fil_addr"}, 32'(fil_addr), 32'd0);
        check_eq({tag, "_wr"}, 32'(out_wr_en), 32'd0);
        check_eq({tag, "_out_addr"}, 32'(out_addr), 32'd0);
        check_eq({tag, "_out_data"}, 32'(out_data), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pool_img [16];
        pool_img = '{1, -5, -1, -2, 3, 2, -3, -4, 7, 0, -8, -9, 4, 6, -7, -10};
        reset    = 1'b1;
        start    = 1'b0;
        mode     = 2'b00;
        img_base = '0;
        fil_base = '0;
        out_base = '0;
        for (int i = 0; i < 64; i++) img_mem[i] = '0;
        for (int i = 0; i < 16; i++) fil_mem[i] = '0;
        repeat (3) @(negedge clock);
        check_zero_outputs("reset");
        reset = 1'b0;

        // Identity filter over a ramp image; start poked mid-run and in DONE
        for (int i = 0; i < 16; i++) img_mem[i] = 8'(i);
        fil_mem[2 + 4] = 8'sd1;
        run_job(2'b00, 0, 2, 20, 1 + 10 + 4 * 11, 1'b0, 20, 1'b1);

        // All-ones filter on an all -1 image
        for (int i = 0; i < 16; i++) img_mem[i] = -8'sd1;
        for (int i = 0; i < 16; i++) fil_mem[i] = (i < 9) ? 8'sd1 : 8'sd0;
        run_job(2'b01, 0, 0, 30, 55, 1'b0, 0, 1'b0);
        run_job(2'b00, 0, 0, 30, 55, 1'b0, 0, 1'b0);

        // Positive and negative saturation
        for (int i = 0; i < 16; i++) img_mem[i] = 8'sd127;
        for (int i = 0; i < 9; i++) fil_mem[i] = 8'sd127;
        run_job(2'b00, 0, 0, 40, 55, 1'b0, 0, 1'b0);
        for (int i = 0; i < 9; i++) fil_mem[i] = -8'sd128;
        run_job(2'b00, 0, 0, 40, 55, 1'b0, 0, 1'b0);

        // 2x2 max pooling
        for (int i = 0; i < 16; i++) img_mem[i] = 8'(pool_img[i]);
        run_job(2'b10, 0, 0, 44, 1 + 4 * 6, 1'b0, 10, 1'b0);

        // Reserved mode
        run_job(2'b11, 0, 0, 0, 1, 1'b1, 0, 1'b0);

        // Reset in the middle of a convolution
        for (int i = 0; i < 64; i++) img_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) fil_mem[i] = 8'($urandom_range(0, 6)) - 8'sd3;
        @(negedge clock);
        mode     = 2'b00;
        img_base = '0;
        fil_base = '0;
        out_base = 6'd50;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_zero_outputs("midreset");
        reset = 1'b0;
        exp_q.delete();

        // Fresh jobs with image, filter and output addresses wrapping
        run_job(2'b00, 60, 12, 62, 55, 1'b0, 0, 1'b0);
        run_job(2'b01, 57, 9, 63, 55, 1'b0, 0, 1'b0);
        run_job(2'b10, 58, 0, 63, 25, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_conv_engine.md
Name: cnn_conv_engine

Overview:
Parametrised convolution/activation/pooling engine for the CNN co-processor. It replaces the single-cycle conv/ReLU/pool ALU path with a sequenced engine that walks a whole image plane from one start command. It reads image and filter memories through synchronous read ports, computes each output pixel by multiply-accumulate or 2x2 max, and writes results back through a write port. It sits between the instruction decode/control stage and the data memories.

Parameters:
N, 8, data width of image, filter and output words (signed two's complement)
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
K, 3, square filter size (K>=1, K<=IMG_W, K<=IMG_H)
M_AW, 10, image/output memory address width
F_AW, 4, filter memory address width (2^F_AW >= K*K)
SHIFT, 0, arithmetic right shift applied to accumulator before saturation
ACC_W, 2*N+$clog2(K*K), accumulator width (derived)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle command pulse; sampled only in IDLE
mode  in  2  00 CONV, 01 CONV_RELU, 10 POOL (2x2, stride 2), 11 reserved
img_base  in  M_AW  image plane base address
fil_base  in  F_AW  filter base address
out_base  in  M_AW  result plane base address
img_rd_en  out  1  image read strobe
img_addr  out  M_AW  image read address
img_data  in  N  image read data, valid 1 cycle after img_rd_en
fil_rd_en  out  1  filter read strobe
fil_addr  out  F_AW  filter read address
fil_data  in  N  filter read data, valid 1 cycle after fil_rd_en
out_wr_en  out  1  result write strobe
out_addr  out  M_AW  result write address
out_data  out  N  result word
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done when mode 11 started

Behaviour:
- Reset: all outputs 0; FSM to IDLE; mode/base/row/col/tap/accumulator registers cleared. Reset mid-operation aborts immediately; no further writes.
- start+mode/bases latched only in IDLE; start while busy ignored.
- FSM: IDLE -> LOAD_F (CONV/CONV_RELU) | RUN (POOL) | DONE with err (mode 11). LOAD_F -> RUN -> WRITE -> RUN (next pixel) or DONE -> IDLE.
- LOAD_F: issues fil_addr=fil_base+t for t=0..K*K-1 on consecutive cycles; coefficient t captured one cycle later; K*K+1 cycles total. Filter index t=i*K+j (row-major).
- CONV output plane OH=IMG_H-K+1, OW=IMG_W-K+1 (valid padding, stride 1); POOL plane IMG_H/2 x IMG_W/2 (floor; odd trailing row/col dropped).
- RUN per pixel (r,c): issues one image read per cycle for taps (i,j) row-major, img_addr=img_base+(r+i)*IMG_W+(c+j) (CONV) or img_base+(2r+i)*IMG_W+(2c+j), i,j in {0,1} (POOL); all addresses modulo 2^M_AW. Accumulator cleared on first tap; CONV: acc+=img*coef signed, full ACC_W precision; POOL: running signed max. RUN lasts T+1 cycles (T=K*K or 4), last cycle only absorbs final data.
- WRITE: exactly one cycle, out_wr_en=1, out_addr=out_base+r*OWid+c modulo 2^M_AW, pixels in raster order. CONV result: acc>>>SHIFT, saturated to [-2^(N-1), 2^(N-1)-1]; CONV_RELU additionally clamps negatives to 0. POOL: max written unmodified.
- Throughput: T+2 cycles per output pixel. 28x28, K=3 CONV: 1 start-accept + 10 LOAD_F + 676*11 RUN/WRITE, then done.
- DONE: done=1 one cycle, busy falls the same cycle, return to IDLE; start in that cycle ignored.
- rd_en strobes low whenever no read is issued; out_addr/out_data hold last value when out_wr_en=0.

Decomposition:
- Package cnn_pkg: mode encoding constants (MODE_CONV, MODE_CONV_RELU, MODE_POOL), FSM state encoding, helper for ACC_W and output-plane dimensions.
- One sub-module: cnn_post (combinational: arithmetic shift, signed saturation, optional ReLU), instantiated at the WRITE stage.

Test Plan:
- Params IMG_W=IMG_H=4,K=3: identity filter (centre=1, rest 0), image = 0..15 raster, CONV -> writes 5,6,9,10 at out_base..+3, done after 1+10+4*11 cycles.
- All-ones filter, image all -1, CONV_RELU -> four writes of 0; CONV -> four writes of -9 (0xF7).
- All coefficients 127, image all 127, CONV -> saturated 127; all -128 filter with 127 image -> -128.
- POOL 4x4 image with 2x2 blocks {1,-5,3,2},{-1,-2,-3,-4},... -> writes 3, -1, ... at out_base.. raster; filter port never strobed.
- start pulsed during RUN and in DONE cycle -> ignored, exactly one done; mode 11 -> done and err together one cycle after accept, no reads/writes.
- reset asserted mid-RUN -> next cycle all outputs 0, IDLE; fresh start completes normally; img_base near 2^M_AW verifies address wrap.
